// File: rtl/sr_latch_driver_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sr_latch_driver_if : producer handshake (dav_/d in, rfd out) for the driver
// Rev 1.0
// ----------------------------------------------------------------------------
interface sr_latch_driver_if;
  logic dav_;
  logic d;
  logic rfd;

  modport master (output dav_, output d, input rfd);
  modport slave  (input dav_, input d, output rfd);
endinterface
`default_nettype wire

// File: rtl/sr_latch_driver.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sr_latch_driver : writes one bit into an external SR latch with timed pulses
// and checks the q/qN readback. Rev 1.0
// ----------------------------------------------------------------------------
module sr_latch_driver #(
  parameter int unsigned PULSE_W = 2,
  parameter int unsigned SETTLE  = 1
) (
  input  wire logic        clock,
  input  wire logic        reset_,
  sr_latch_driver_if.slave prod,
  output logic             s,
  output logic             r,
  output logic             preset_,
  output logic             preclear_,
  input  wire logic        q,
  input  wire logic        qN,
  output logic             cur,
  output logic             err
);

  typedef enum logic [2:0] {
    ST_INIT    = 3'd0,
    ST_IDLE    = 3'd1,
    ST_PULSE   = 3'd2,
    ST_SETTLE  = 3'd3,
    ST_CHECK   = 3'd4,
    ST_WAITDAV = 3'd5
  } state_t;

  localparam logic [3:0] c_pulse_w = 4'(PULSE_W);
  localparam logic [3:0] c_settle  = 4'(SETTLE);
  // A zero settle time skips the SETTLE state entirely.
  localparam state_t     c_post_pulse = (SETTLE == 0) ? ST_CHECK : ST_SETTLE;

  state_t     state_q;
  logic [3:0] pulse_cnt_q;
  logic [3:0] settle_cnt_q;
  logic       s_q;
  logic       r_q;
  logic       preset_q;
  logic       preclear_q;
  logic       rfd_q;
  logic       cur_q;
  logic       err_q;
  logic       from_init_q;
  logic       w_latch_ok;

  assign w_latch_ok = (q == cur_q) && (qN == ~cur_q);

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state_q      <= ST_INIT;
      pulse_cnt_q  <= c_pulse_w;
      settle_cnt_q <= c_pulse_w;
      s_q          <= 1'b0;
      r_q          <= 1'b0;
      preset_q     <= 1'b1;
      preclear_q   <= 1'b0;
      rfd_q        <= 1'b0;
      cur_q        <= 1'b0;
      err_q        <= 1'b0;
      from_init_q  <= 1'b1;
    end else begin
      case (state_q)
        ST_INIT: begin
          if (pulse_cnt_q <= 4'd1) begin
            pulse_cnt_q  <= 4'd0;
            settle_cnt_q <= c_settle;
            preclear_q   <= 1'b1;
            state_q      <= c_post_pulse;
          end else begin
            pulse_cnt_q <= pulse_cnt_q - 4'd1;
          end
        end

        ST_IDLE: begin
          rfd_q <= 1'b1;
          if (!prod.dav_) begin
            cur_q       <= prod.d;
            rfd_q       <= 1'b0;
            s_q         <= prod.d;
            r_q         <= ~prod.d;
            pulse_cnt_q <= c_pulse_w;
            from_init_q <= 1'b0;
            state_q     <= ST_PULSE;
          end
        end

        ST_PULSE: begin
          if (pulse_cnt_q <= 4'd1) begin
            pulse_cnt_q  <= 4'd0;
            settle_cnt_q <= c_settle;
            s_q          <= 1'b0;
            r_q          <= 1'b0;
            state_q      <= c_post_pulse;
          end else begin
            pulse_cnt_q <= pulse_cnt_q - 4'd1;
          end
        end

        ST_SETTLE: begin
          if (settle_cnt_q <= 4'd1) begin
            settle_cnt_q <= 4'd0;
            state_q      <= ST_CHECK;
          end else begin
            settle_cnt_q <= settle_cnt_q - 4'd1;
          end
        end

        ST_CHECK: begin
          err_q <= ~w_latch_ok;
          // The init sequence has no producer to wait for.
          if (from_init_q) begin
            rfd_q   <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            state_q <= ST_WAITDAV;
          end
        end

        ST_WAITDAV: begin
          if (prod.dav_) begin
            rfd_q   <= 1'b1;
            state_q <= ST_IDLE;
          end
        end

        default: begin
          state_q     <= ST_INIT;
          pulse_cnt_q <= c_pulse_w;
          s_q         <= 1'b0;
          r_q         <= 1'b0;
          preset_q    <= 1'b1;
          preclear_q  <= 1'b0;
          rfd_q       <= 1'b0;
          from_init_q <= 1'b1;
        end
      endcase
    end
  end

  assign prod.rfd  = rfd_q;
  assign s         = s_q;
  assign r         = r_q;
  assign preset_   = preset_q;
  assign preclear_ = preclear_q;
  assign cur       = cur_q;
  assign err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_sr_latch_driver.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_sr_latch_driver : random and directed writes against a behavioural latch
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_sr_latch_driver;

  localparam int PW = 2;
  localparam int ST = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Main instance with default parameters
  sr_latch_driver_if m_bus ();
  logic m_rst_n;
  logic m_s, m_r, m_preset_n, m_preclear_n, m_q, m_qN, m_cur, m_err;
  logic m_lq = 1'b0;
  int   m_mode = 0;   // 0 healthy latch, 1 stuck q=0/qN=1, 2 q=qN=1

  sr_latch_driver u_dut (
    .clock     (clk),
    .reset_    (m_rst_n),
    .prod      (m_bus),
    .s         (m_s),
    .r         (m_r),
    .preset_   (m_preset_n),
    .preclear_ (m_preclear_n),
    .q         (m_q),
    .qN        (m_qN),
    .cur       (m_cur),
    .err       (m_err)
  );

  always @(m_s or m_r or m_preset_n or m_preclear_n) begin
    if (!m_preclear_n)    m_lq = 1'b0;
    else if (!m_preset_n) m_lq = 1'b1;
    else if (m_s)         m_lq = 1'b1;
    else if (m_r)         m_lq = 1'b0;
  end
  assign m_q  = (m_mode == 1) ? 1'b0 : (m_mode == 2) ? 1'b1 : m_lq;
  assign m_qN = (m_mode == 0) ? ~m_lq : 1'b1;

  always @(negedge clk)
    chk("m_invariants", int'({m_s & m_r, ~m_preset_n & ~m_preclear_n,
                              (m_s | m_r) & ~(m_preset_n & m_preclear_n)}), 0);

  task automatic m_init();
    int pc_low = 0;
    int first  = -1;
    m_mode  = 0;
    m_rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_s",        int'(m_s), 0);
    chk("rst_r",        int'(m_r), 0);
    chk("rst_preset_",  int'(m_preset_n), 1);
    chk("rst_preclear_", int'(m_preclear_n), 0);
    chk("rst_rfd",      int'(m_bus.rfd), 0);
    chk("rst_err",      int'(m_err), 0);
    chk("rst_cur",      int'(m_cur), 0);
    m_rst_n = 1'b1;
    for (int k = 0; k <= 60; k++) begin
      if (k > 0) @(negedge clk);
      pc_low += int'(!m_preclear_n);
      if (m_bus.rfd) begin
        first = k;
        break;
      end
    end
    chk("init_preclear_cycles", pc_low, PW);
    chk("init_first_rfd_edge", first, PW + ST + 1);
    chk("init_err", int'(m_err), 0);
    chk("init_cur", int'(m_cur), 0);
  endtask

  // One handshaked write; expectations follow from pulse width, settle time,
  // how long the producer holds dav_ low and what the latch reads back.
  task automatic m_write(input logic dv, input int hold, input int mode);
    int   s_cnt = 0;
    int   r_cnt = 0;
    int   low   = -1;
    int   exp_low;
    logic q_exp, qn_exp, exp_err;
    for (int k = 0; k < 100 && !m_bus.rfd; k++) @(negedge clk);
    chk("m_ready", int'(m_bus.rfd), 1);
    m_mode      = mode;
    m_bus.d     = dv;
    m_bus.dav_  = 1'b0;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (k == 1) m_bus.d = ~dv;
      s_cnt += int'(m_s);
      r_cnt += int'(m_r);
      if (k == hold) m_bus.dav_ = 1'b1;
      if (m_bus.rfd) begin
        low = k - 1;
        break;
      end
    end
    m_bus.dav_ = 1'b1;
    q_exp   = (mode == 1) ? 1'b0 : (mode == 2) ? 1'b1 : dv;
    qn_exp  = (mode == 0) ? ~dv : 1'b1;
    exp_err = !((q_exp == dv) && (qn_exp == !dv));
    exp_low = (hold > PW + ST + 2) ? hold : PW + ST + 2;
    chk("s_pulse_cycles", s_cnt, dv ? PW : 0);
    chk("r_pulse_cycles", r_cnt, dv ? 0 : PW);
    chk("rfd_low_cycles", low, exp_low);
    chk("cur_after_write", int'(m_cur), int'(dv));
    chk("err_after_write", int'(m_err), int'(exp_err));
  endtask

  // Extra instances for the extreme parameter settings
  logic [1:0] cfg_done;

  for (genvar gi = 0; gi < 2; gi++) begin : g_cfg
    localparam int CPW = (gi == 0) ? 1 : 15;
    localparam int CST = (gi == 0) ? 0 : 15;

    sr_latch_driver_if bus ();
    logic rst_n = 1'b0;
    logic done  = 1'b0;
    logic lq    = 1'b0;
    logic s, r, preset_n, preclear_n, q, qn, cur, err;

    sr_latch_driver #(.PULSE_W(CPW), .SETTLE(CST)) u_dut (
      .clock     (clk),
      .reset_    (rst_n),
      .prod      (bus),
      .s         (s),
      .r         (r),
      .preset_   (preset_n),
      .preclear_ (preclear_n),
      .q         (q),
      .qN        (qn),
      .cur       (cur),
      .err       (err)
    );

    always @(s or r or preset_n or preclear_n) begin
      if (!preclear_n)    lq = 1'b0;
      else if (!preset_n) lq = 1'b1;
      else if (s)         lq = 1'b1;
      else if (r)         lq = 1'b0;
    end
    assign q  = lq;
    assign qn = ~lq;
    assign cfg_done[gi] = done;

    always @(negedge clk)
      chk("cfg_invariants", int'({s & r, ~preset_n & ~preclear_n,
                                  (s | r) & ~(preset_n & preclear_n)}), 0);

    initial begin
      int   s_cnt, r_cnt, low, hold, exp_low;
      logic dv;
      bus.dav_ = 1'b1;
      bus.d    = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      for (int w = 0; w < 200; w++) begin
        for (int k = 0; k < 200 && !bus.rfd; k++) @(negedge clk);
        chk("cfg_ready", int'(bus.rfd), 1);
        dv       = 1'($urandom);
        hold     = $urandom_range(1, CPW + CST + 4);
        exp_low  = (hold > CPW + CST + 2) ? hold : CPW + CST + 2;
        s_cnt    = 0;
        r_cnt    = 0;
        low      = -1;
        bus.d    = dv;
        bus.dav_ = 1'b0;
        for (int k = 1; k <= 200; k++) begin
          @(negedge clk);
          if (k == 1) bus.d = ~dv;
          s_cnt += int'(s);
          r_cnt += int'(r);
          if (k == hold) bus.dav_ = 1'b1;
          if (bus.rfd) begin
            low = k - 1;
            break;
          end
        end
        bus.dav_ = 1'b1;
        chk("cfg_pulse_cycles", dv ? s_cnt : r_cnt, CPW);
        chk("cfg_other_line", dv ? r_cnt : s_cnt, 0);
        chk("cfg_rfd_low", low, exp_low);
        chk("cfg_cur", int'(cur), int'(dv));
        chk("cfg_err", int'(err), 0);
      end
      done = 1'b1;
    end
  end

  initial begin
    m_bus.dav_ = 1'b1;
    m_bus.d    = 1'b0;
    m_rst_n    = 1'b0;
    @(negedge clk);
    m_init();

    m_write(1'b1, 1, 0);
    m_write(1'b0, 10, 0);
    m_write(1'b0, 1, 0);
    m_write(1'b1, 2, 0);
    m_write(1'b1, 1, 0);
    m_write(1'b1, 1, 1);
    repeat (3) @(negedge clk);
    chk("err_holds", int'(m_err), 1);
    m_write(1'b0, 1, 1);
    m_write(1'b1, 3, 2);
    m_write(1'b0, 1, 0);

    // Reset arriving while s is being driven
    for (int k = 0; k < 100 && !m_bus.rfd; k++) @(negedge clk);
    m_mode     = 0;
    m_bus.d    = 1'b1;
    m_bus.dav_ = 1'b0;
    @(negedge clk);
    chk("midpulse_s_active", int'(m_s), 1);
    #1 m_rst_n = 1'b0;
    #1;
    chk("async_s_drop", int'(m_s), 0);
    chk("async_preclear_", int'(m_preclear_n), 0);
    chk("async_rfd", int'(m_bus.rfd), 0);
    m_bus.dav_ = 1'b1;
    @(negedge clk);
    m_init();

    for (int w = 0; w < 200; w++)
      m_write(1'($urandom), $urandom_range(1, 8), $urandom_range(0, 2));

    for (int k = 0; k < 60000 && cfg_done != 2'b11; k++) @(negedge clk);
    chk("cfg_runs_complete", int'(cfg_done), 3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
